// File: rtl/jtag_ctrl_pkg.sv
// rtl/jtag_ctrl_pkg.sv - shared constants, TMS patterns and FSM states for the JTAG scan arbiter
package jtag_ctrl_pkg;

    localparam int MAX_LEN_DEFAULT = 32;
    localparam int TLR_WALK_LEN    = 5;

    // TMS patterns are applied LSB first.
    localparam logic [2:0] DR_HDR_PAT = 3'b001;
    localparam logic [3:0] IR_HDR_PAT = 4'b0011;
    localparam logic [1:0] TAIL_PAT   = 2'b01;

    typedef enum logic [2:0] {
        ST_TLR_WALK,
        ST_IDLE,
        ST_HDR,
        ST_SHIFT,
        ST_TAIL,
        ST_DONE
    } state_e;

    function automatic logic hdr_bit(input logic ir, input logic [1:0] idx);
        logic [3:0] pat;
        pat = ir ? IR_HDR_PAT : {1'b0, DR_HDR_PAT};
        return pat[idx];
    endfunction

endpackage

// File: rtl/jtag_rr_arb2.sv
// rtl/jtag_rr_arb2.sv - two-way round-robin arbiter; last-grant pointer advances on done
module jtag_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [1:0] done_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    logic last_q;

    always_comb begin
        idx_o = (req_i == 2'b11) ? ~last_q : req_i[1];
        gnt_o = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o = idx_o ? 2'b10 : 2'b01;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|done_i) begin
            last_q <= done_i[1];
        end
    end

endmodule

// File: rtl/jtag_scan_arbiter.sv
// rtl/jtag_scan_arbiter.sv - shares one JTAG TAP between two scan requesters, runs full IR/DR scans
module jtag_scan_arbiter
    import jtag_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [1:0]           req_ir,
    input  logic [2*LEN_W-1:0]   req_len,
    input  logic [2*MAX_LEN-1:0] req_data,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic [MAX_LEN-1:0]   rsp_data,
    output logic                 ready,
    output logic                 tck,
    output logic                 tms,
    output logic                 tdi,
    input  logic                 tdo
);

    state_e             state_q, state_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         done_q, done_d;
    logic [MAX_LEN-1:0] rsp_q, rsp_d;
    logic               ready_q, ready_d;
    logic               ir_q, ir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         arb_gnt;
    logic               arb_idx;
    logic [LEN_W-1:0]   sel_len_raw;
    logic [LEN_W-1:0]   sel_len;
    logic [LEN_W-1:0]   hdr_last;
    logic [MAX_LEN-1:0] rsp_aligned;

    jtag_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .done_i (done_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    assign sel_len_raw = arb_idx ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    assign sel_len     = (sel_len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : sel_len_raw;
    assign hdr_last    = ir_q ? LEN_W'(3) : LEN_W'(2);
    // TDO enters at the MSB end; shift the captured bits down to [len-1:0].
    assign rsp_aligned = cap_q >> (LEN_W'(MAX_LEN) - len_q);

    always_comb begin
        state_d = state_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        rsp_d   = rsp_q;
        ready_d = ready_q;
        ir_d    = ir_q;
        len_d   = len_q;
        data_d  = data_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_TLR_WALK: begin
                tck_d = ~tck_q;
                if (tck_q) begin
                    if (cnt_q == LEN_W'(TLR_WALK_LEN)) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        tms_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        tms_d = (cnt_d < LEN_W'(TLR_WALK_LEN));
                    end
                end
            end
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_HDR;
                    gnt_d   = arb_gnt;
                    ready_d = 1'b0;
                    ir_d    = arb_idx ? req_ir[1] : req_ir[0];
                    len_d   = sel_len;
                    data_d  = arb_idx ? req_data[2*MAX_LEN-1:MAX_LEN] : req_data[MAX_LEN-1:0];
                    cap_d   = '0;
                    cnt_d   = '0;
                    tck_d   = 1'b0;
                    tdi_d   = 1'b0;
                    // Both header patterns start with TMS=1; a zero-length scan leaves the TAP untouched.
                    tms_d   = (sel_len != '0);
                end
            end
            ST_HDR: begin
                if (len_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                    rsp_d   = '0;
                    gnt_d   = 2'b00;
                end else begin
                    tck_d = ~tck_q;
                    if (tck_q) begin
                        if (cnt_q == hdr_last) begin
                            state_d = ST_SHIFT;
                            cnt_d   = '0;
                            tms_d   = (len_q == LEN_W'(1));
                            tdi_d   = data_q[0];
                            data_d  = data_q >> 1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            tms_d = hdr_bit(ir_q, cnt_d[1:0]);
                        end
                    end
                end
            end
            ST_SHIFT: begin
                tck_d = ~tck_q;
                if (!tck_q) begin
                    cap_d = {tdo, cap_q[MAX_LEN-1:1]};
                end else if (cnt_q == len_q - 1'b1) begin
                    state_d = ST_TAIL;
                    cnt_d   = '0;
                    tms_d   = TAIL_PAT[0];
                    tdi_d   = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    tms_d  = (cnt_d == len_q - 1'b1);
                    tdi_d  = data_q[0];
                    data_d = data_q >> 1;
                end
            end
            ST_TAIL: begin
                tck_d = ~tck_q;
                if (tck_q) begin
                    if (cnt_q != '0) begin
                        state_d = ST_DONE;
                        done_d  = gnt_q;
                        rsp_d   = rsp_aligned;
                        gnt_d   = 2'b00;
                        tms_d   = 1'b0;
                    end else begin
                        cnt_d = LEN_W'(1);
                        tms_d = TAIL_PAT[1];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_TLR_WALK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_TLR_WALK;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            rsp_q   <= '0;
            ready_q <= 1'b0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rsp_q   <= rsp_d;
            ready_q <= ready_d;
            ir_q    <= ir_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rsp_data = rsp_q;
    assign ready    = ready_q;
    assign tck      = tck_q;
    assign tms      = tms_q;
    assign tdi      = tdi_q;

endmodule

// File: tb/tb_jtag_scan_arbiter.sv
// tb/tb_jtag_scan_arbiter.sv - table-driven, scoreboarded bench for jtag_scan_arbiter
module tb_jtag_scan_arbiter;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req = '0;
    logic [1:0]           req_ir = '0;
    logic [2*LEN_W-1:0]   req_len = '0;
    logic [2*MAX_LEN-1:0] req_data = '0;
    logic [1:0]           gnt, done;
    logic [MAX_LEN-1:0]   rsp_data;
    logic                 ready, tck, tms, tdi, tdo;
    int                   tdo_mode = 0;

    assign tdo = (tdo_mode == 0) ? tdi : ((tdo_mode == 1) ? 1'b1 : 1'b0);

    jtag_scan_arbiter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ir(req_ir), .req_len(req_len),
        .req_data(req_data), .gnt(gnt), .done(done), .rsp_data(rsp_data),
        .ready(ready), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          ir;
        int          len;
        logic [31:0] data;
        int          mode;
        logic [31:0] exp_rsp;
        int          exp_ntck;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rsp;
        int          ntck;
        logic [63:0] tms;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] tms_model(input bit ir, input int lenc);
        logic [63:0] t;
        int p;
        t = '0;
        p = 0;
        if (lenc == 0) return t;
        t[p] = 1'b1; p++;
        if (ir) begin t[p] = 1'b1; p++; end
        t[p] = 1'b0; p++;
        t[p] = 1'b0; p++;
        for (int k = 0; k < lenc; k++) begin
            t[p] = (k == lenc - 1); p++;
        end
        t[p] = 1'b1; p++;
        t[p] = 1'b0;
        return t;
    endfunction

    // Monitor: logs TMS at every TCK rise since grant and scores each done pulse.
    logic [63:0] tms_log = '0;
    int          ntms = 0;
    int          cyc = 0;
    int          grant_cyc = 0;
    logic        prev_tck = 1'b0;
    logic [1:0]  prev_gnt = '0;
    bit          both_seen = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_tck = 1'b0;
            prev_gnt = '0;
        end else begin
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                tms_log   = '0;
                ntms      = 0;
                grant_cyc = cyc;
            end
            if (tck && !prev_tck && ntms < 64) begin
                tms_log[ntms] = tms;
                ntms++;
            end
            if (gnt == 2'b11) both_seen = 1'b1;
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_idx", done, 2'b01 << e.idx);
                    chk("rsp_data", rsp_data, e.rsp);
                    chk("tck_count", ntms, e.ntck);
                    chk("tms_stream", tms_log, e.tms);
                    chk("done_latency", cyc - grant_cyc, e.lat);
                    chk("gnt_clear_at_done", gnt, 0);
                end
            end
            prev_tck = tck;
            prev_gnt = gnt;
        end
    end

    task automatic set_fields(input vec_t v);
        req_ir[v.idx]                   = v.ir;
        req_len[v.idx*LEN_W +: LEN_W]   = LEN_W'(v.len);
        req_data[v.idx*MAX_LEN +: MAX_LEN] = v.data;
        tdo_mode                        = v.mode;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        int lenc;
        lenc   = (v.len > MAX_LEN) ? MAX_LEN : v.len;
        e.idx  = v.idx;
        e.rsp  = v.exp_rsp;
        e.ntck = v.exp_ntck;
        e.tms  = tms_model(v.ir, lenc);
        e.lat  = (v.exp_ntck == 0) ? 1 : 2 * v.exp_ntck;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input int idx, output int n, output int pre_done);
        n = 0;
        pre_done = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done != 2'b00) pre_done++;
            if (gnt[idx]) begin n = k; break; end
        end
        if (n == 0) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        int ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok == 0) chk("ready_timeout", 0, 1);
    endtask

    // Drive one scan; the request is dropped and the inputs scrambled right after grant.
    task automatic do_scan(input vec_t v, output int n, output int pre_done);
        set_fields(v);
        push_exp(v);
        req[v.idx] = 1'b1;
        wait_gnt(v.idx, n, pre_done);
        req[v.idx] = 1'b0;
        req_ir[v.idx] = ~v.ir;
        req_len[v.idx*LEN_W +: LEN_W] = LEN_W'(7);
        req_data[v.idx*MAX_LEN +: MAX_LEN] = ~v.data;
        @(negedge clk);
        wait_ready();
    endtask

    vec_t vecs[7];

    initial begin
        int n, pre_done, rises, ndone;
        logic pt;
        logic [5:0] walk_tms;
        bit toggle_ok;
        vec_t v;

        vecs[0] = '{0, 1'b0,  8, 32'h000000A5, 0, 32'h000000A5, 13};
        vecs[1] = '{1, 1'b1,  4, 32'h0000000E, 1, 32'h0000000F, 10};
        vecs[2] = '{0, 1'b0,  0, 32'h000000FF, 0, 32'h00000000,  0};
        vecs[3] = '{1, 1'b0, 40, 32'hDEADBEEF, 0, 32'hDEADBEEF, 37};
        vecs[4] = '{0, 1'b1, 32, 32'h12345678, 0, 32'h12345678, 38};
        vecs[5] = '{0, 1'b0,  1, 32'h00000001, 0, 32'h00000001,  6};
        vecs[6] = '{1, 1'b0,  5, 32'h0000001F, 2, 32'h00000000, 10};

        // Reset values and the TLR walk.
        repeat (3) @(negedge clk);
        chk("rst_tck", tck, 0);
        chk("rst_tms", tms, 1);
        chk("rst_tdi", tdi, 0);
        chk("rst_gnt_done_ready", {gnt, done, ready}, 0);
        chk("rst_rsp", rsp_data, 0);
        rst = 1'b0;
        n = 0;
        rises = 0;
        pt = 1'b0;
        toggle_ok = 1'b1;
        walk_tms = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 12 && tck !== c[0]) toggle_ok = 1'b0;
            if (tck && !pt && rises < 6) begin walk_tms[rises] = tms; rises++; end
            pt = tck;
            if (ready) begin n = c; break; end
        end
        chk("walk_ready_cycle", n, 12);
        chk("walk_tck_toggle", toggle_ok, 1);
        chk("walk_tck_rises", rises, 6);
        chk("walk_tms", walk_tms, 6'b011111);

        for (int i = 0; i < 7; i++) begin
            do_scan(vecs[i], n, pre_done);
        end

        // Reset during shift bit 3 of a DR scan.
        v = '{0, 1'b0, 8, 32'h000000A5, 0, 32'h000000A5, 13};
        set_fields(v);
        req[0] = 1'b1;
        wait_gnt(0, n, pre_done);
        req[0] = 1'b0;
        rises = 0;
        pt = tck;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tck && !pt) rises++;
            pt = tck;
            if (rises == 7) break;
        end
        chk("mid_rst_reached_bit3", rises, 7);
        rst = 1'b1;
        #1;
        chk("mid_rst_tms", tms, 1);
        chk("mid_rst_tck", tck, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_ready", ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        v = '{1, 1'b0, 3, 32'h00000005, 0, 32'h00000005, 8};
        do_scan(v, n, pre_done);
        chk("post_rst_grant_cycle", n, 13);
        chk("post_rst_no_done", pre_done, 0);

        // Both requesters held: grants must alternate 0,1,0,1.
        set_fields('{0, 1'b0, 2, 32'h00000002, 0, 32'h00000002, 7});
        set_fields('{1, 1'b0, 2, 32'h00000001, 0, 32'h00000001, 7});
        push_exp('{0, 1'b0, 2, 32'h00000002, 0, 32'h00000002, 7});
        push_exp('{1, 1'b0, 2, 32'h00000001, 0, 32'h00000001, 7});
        push_exp('{0, 1'b0, 2, 32'h00000002, 0, 32'h00000002, 7});
        push_exp('{1, 1'b0, 2, 32'h00000001, 0, 32'h00000001, 7});
        req = 2'b11;
        ndone = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (done != 2'b00) ndone++;
            if (ndone == 4) break;
        end
        req = 2'b00;
        chk("alt_done_count", ndone, 4);
        wait_ready();
        repeat (4) @(negedge clk);
        chk("gnt_onehot", both_seen, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
